// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, EX redirects, data-memory waits.
// Define PIPE_HAZARD_PERF_EN to build the saturating performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        mem_req,
   input  logic        mem_ack,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        id_ex_stall,
   output logic        ex_mem_stall,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        mem_wb_flush,
   output logic        mem_err,
   output logic [1:0]  state,
   output logic [31:0] perf_stall_cyc,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_lu_cnt
);

   localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StMemErr  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mem_err_q;
   logic            mstall;
   logic            lu_hit;

   assign mstall = mem_req && !mem_ack && (state_q != StMemErr);

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign lu_hit = ex_is_load && (ex_rd != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRun;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_q | (state_d == StMemErr);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            if (mstall) begin
               state_d = StMemWait;
               cnt_d   = CntW'(1);
            end
         end
         StMemWait: begin
            if (!mem_req || mem_ack) begin
               state_d = StRun;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(MEM_TIMEOUT)) begin
               state_d = StMemErr;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StMemErr: state_d = StMemErr;
         default: begin
            state_d = StRun;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (rst) begin
         pc_stall = 1'b0;
      end else if ((state_q == StMemErr) || mstall) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
         // The load-use instruction in ID is squashed by the redirect, so no stall is needed.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu_hit) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   assign mem_err = mem_err_q;
   assign state   = state_q;

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_q, flush_q, lu_q;
   logic        lu_bubble;

   // Only the load-use response stalls the PC without also stalling EX/MEM.
   assign lu_bubble = pc_stall && !ex_mem_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
         lu_q    <= '0;
      end else begin
         if (pc_stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + 32'd1;
         if (lu_bubble && (lu_q != '1)) lu_q <= lu_q + 32'd1;
      end
   end

   assign perf_stall_cyc = stall_q;
   assign perf_flush_cnt = flush_q;
   assign perf_lu_cnt    = lu_q;
`else
   assign perf_stall_cyc = '0;
   assign perf_flush_cnt = '0;
   assign perf_lu_cnt    = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC hold. Resolves three hazard sources in one place: load-use data hazards, control redirects resolved in EX, and multi-cycle data-memory waits. A small FSM tracks memory waits and a timeout that freezes the pipeline on a hung bus.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: number of MEM_WAIT cycles without `mem_ack` before entering MEM_ERR; legal range 1..65535.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_is_load`  in  1  the EX instruction is a load.
- `ex_redirect`  in  1  branch taken or jump resolved in EX; PC is being redirected.
- `mem_req`  in  1  the MEM instruction accesses data memory.
- `mem_ack`  in  1  data memory completes the access this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1 each  hold the PC / register.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1 each  load a bubble (all-zero) into the register.
- `mem_err`  out  1  sticky bus-timeout flag.
- `state`  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 MEM_ERR.
- `perf_stall_cyc`, `perf_flush_cnt`, `perf_lu_cnt`  out  32 each  performance counters; see Configuration.

## Operation
- Priority, highest first: rst > MEM_ERR > memory stall > redirect > load-use.
- Memory stall (`mstall`) = `mem_req && !mem_ack` in RUN or MEM_WAIT. Asserts `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_flush`. Suppresses all other flushes and stalls.
- Redirect (no mstall): `ex_redirect` asserts `if_id_flush` and `id_ex_flush`. PC is not stalled; it loads the target. A redirect held during mstall takes effect on the first non-stalled cycle.
- Load-use (no mstall, no redirect):
  - Condition: `ex_is_load && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd))`.
  - Response: asserts `pc_stall`, `if_id_stall`, `id_ex_flush`, giving exactly one bubble per occurrence.
- x0 never creates a hazard.
- FSM:
  - RUN → MEM_WAIT when mstall; the wait counter loads 1.
  - MEM_WAIT: counter increments every cycle with mstall. `mem_ack` → RUN with stalls deasserted in that same cycle. `mem_req` dropping → RUN.
  - MEM_WAIT → MEM_ERR when the counter equals `MEM_TIMEOUT` and `mem_ack` is low.
  - MEM_ERR: all four stalls and `mem_wb_flush` held high, `mem_err` = 1. Exit only via `rst`.
- Counter width is ceil(log2(MEM_TIMEOUT+1)) and it never wraps.

## Timing
- All stall/flush outputs are combinational from inputs and registered state, valid in the same cycle as the hazard. No latency.
- `state`, the wait counter, `mem_err` and the perf counters are registered.
- While `rst` = 1: every stall/flush output = 0. On the edge, `state` = RUN, counter = 0, `mem_err` = 0, perf counters = 0.
- Reset asserted mid-MEM_WAIT or in MEM_ERR returns to RUN at the next edge regardless of `mem_ack`.
- `mem_ack` on the same cycle as `mem_req` rising: no stall, FSM stays in RUN.
- Simultaneous redirect and load-use: redirect wins, with no stall; the load-use instruction is flushed anyway.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined: three 32-bit saturating counters (hold at 0xFFFFFFFF), each incrementing on a rising edge with `rst` low:
  - `perf_stall_cyc`: +1 every cycle `pc_stall` is high.
  - `perf_flush_cnt`: +1 every cycle `if_id_flush` is high.
  - `perf_lu_cnt`: +1 every load-use bubble.
- `PIPE_HAZARD_PERF_EN` undefined: no counter flops; the three outputs are tied to 0.

## Test plan
- Load-use: `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_rs2_used`=1 for one cycle → `pc_stall`=`if_id_stall`=`id_ex_flush`=1 that cycle only. Same stimulus with `ex_rd`=0 → all outputs 0.
- Redirect: `ex_redirect`=1 together with a load-use match → `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0.
- Memory wait: `mem_req`=1, `mem_ack`=0 for 3 cycles, then `mem_ack`=1 → `state` 0→1, stalls and `mem_wb_flush` high for 3 cycles, all low on the ack cycle, `state`=0 next.
- Timeout: `MEM_TIMEOUT`=4, `mem_req`=1, `mem_ack` never → `state`=2 after 4 MEM_WAIT cycles, `mem_err`=1 sticky, stalls held. Then `rst` pulse → `state`=0, `mem_err`=0.
- Redirect held during a memory wait: `ex_redirect`=1 throughout a 2-cycle wait → flushes 0 while stalled, `if_id_flush`=1 on the ack cycle.
- With `PIPE_HAZARD_PERF_EN`: after the memory-wait scenario, `perf_stall_cyc`=3. Without the macro, `perf_stall_cyc`=0.
